// File: rtl/cv32e40p_if_id_tmr_scrub_ctrl.sv
// Majority voter and scrub controller for the triplicated IF/ID pipeline registers.
// Vote is combinational; a mismatch stalls IF for one cycle while the faulty copies are rewritten.
module cv32e40p_if_id_tmr_scrub_ctrl #(
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            lane_valid_i,
  input  logic [2:0][31:0]      lane_rdata_i,
  input  logic [2:0][31:0]      lane_pc_i,
  input  logic [2:0][2:0]       lane_flags_i,
  output logic                  voted_valid_o,
  output logic [31:0]           voted_rdata_o,
  output logic [31:0]           voted_pc_o,
  output logic [2:0]            voted_flags_o,
  output logic [2:0]            wr_en_o,
  output logic                  wr_valid_o,
  output logic [31:0]           wr_rdata_o,
  output logic [31:0]           wr_pc_o,
  output logic [2:0]            wr_flags_o,
  output logic                  stall_o,
  output logic                  corr_o,
  output logic [2:0]            lane_en_o,
  output logic [2:0][CNT_W-1:0] err_cnt_o,
  output logic                  fatal_o,
  input  logic                  clr_cnt_i
);

  localparam int unsigned      BW      = 68;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {MONITOR, CORRECT, FAIL} state_e;

  state_e                  state;
  logic [2:0][BW-1:0]      bundle;
  logic [BW-1:0]           maj;
  logic [BW-1:0]           voted;
  logic [BW-1:0]           wr_bundle;
  logic [2:0]              mism;
  logic [2:0]              retire;
  logic [2:0]              keep;
  logic                    all_en;
  logic                    keep_ok;

  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign bundle[i] = {lane_valid_i[i], lane_rdata_i[i], lane_pc_i[i], lane_flags_i[i]};
    assign mism[i]   = lane_en_o[i] & (bundle[i] != voted);
    assign retire[i] = lane_en_o[i] & (err_cnt_o[i] >= THRESH);
  end

  assign maj = (bundle[0] & bundle[1]) | (bundle[1] & bundle[2]) | (bundle[0] & bundle[2]);

  // With one lane retired there is no majority; trust the lower-index survivor.
  always_comb begin
    voted = maj;
    case (lane_en_o)
      3'b110:  voted = bundle[1];
      3'b101:  voted = bundle[0];
      3'b011:  voted = bundle[0];
      default: voted = maj;
    endcase
  end

  assign all_en  = &lane_en_o;
  assign keep    = lane_en_o & ~retire;
  assign keep_ok = $countones(keep) >= 2;

  assign voted_valid_o = voted[67];
  assign voted_rdata_o = voted[66:35];
  assign voted_pc_o    = voted[34:3];
  assign voted_flags_o = voted[2:0];

  assign wr_valid_o = wr_bundle[67];
  assign wr_rdata_o = wr_bundle[66:35];
  assign wr_pc_o    = wr_bundle[34:3];
  assign wr_flags_o = wr_bundle[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MONITOR;
      lane_en_o <= 3'b111;
      err_cnt_o <= '0;
      fatal_o   <= 1'b0;
      stall_o   <= 1'b0;
      corr_o    <= 1'b0;
      wr_en_o   <= 3'b000;
      wr_bundle <= '0;
    end else begin
      corr_o  <= 1'b0;
      wr_en_o <= 3'b000;
      case (state)
        MONITOR: begin
          stall_o <= 1'b0;
          if (|mism) begin
            if (all_en) begin
              state     <= CORRECT;
              wr_bundle <= voted;
              wr_en_o   <= mism;
              stall_o   <= 1'b1;
              corr_o    <= 1'b1;
            end else begin
              state   <= FAIL;
              fatal_o <= 1'b1;
              stall_o <= 1'b1;
            end
          end
        end
        CORRECT: begin
          // Retiring too many lanes would leave nothing to compare against.
          if (keep_ok) begin
            state     <= MONITOR;
            lane_en_o <= keep;
            stall_o   <= 1'b0;
          end else begin
            state   <= FAIL;
            fatal_o <= 1'b1;
            stall_o <= 1'b1;
          end
        end
        FAIL: begin
          fatal_o <= 1'b1;
          stall_o <= 1'b1;
        end
        default: begin
          state   <= MONITOR;
          stall_o <= 1'b0;
        end
      endcase

      for (int i = 0; i < 3; i++) begin
        if (clr_cnt_i) begin
          err_cnt_o[i] <= '0;
        end else if ((state == MONITOR) && all_en && mism[i] && (err_cnt_o[i] != CNT_MAX)) begin
          err_cnt_o[i] <= err_cnt_o[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_if_id_tmr_scrub_ctrl.sv
// Bench for the IF/ID TMR scrub controller; corrections are scoreboarded against a queue.
module tb_cv32e40p_if_id_tmr_scrub_ctrl;

  localparam int CNT_W      = 3;
  localparam int ERR_THRESH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PC  = 32'h0000_0080;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [2:0]            lane_valid;
  logic [2:0][31:0]      lane_rdata;
  logic [2:0][31:0]      lane_pc;
  logic [2:0][2:0]       lane_flags;
  logic                  clr_cnt = 1'b0;
  logic                  voted_valid;
  logic [31:0]           voted_rdata;
  logic [31:0]           voted_pc;
  logic [2:0]            voted_flags;
  logic [2:0]            wr_en;
  logic                  wr_valid;
  logic [31:0]           wr_rdata;
  logic [31:0]           wr_pc;
  logic [2:0]            wr_flags;
  logic                  stall;
  logic                  corr;
  logic [2:0]            lane_en;
  logic [2:0][CNT_W-1:0] err_cnt;
  logic                  fatal;

  typedef struct packed {
    logic [2:0]  en;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  flags;
  } corr_t;

  corr_t corr_q[$];
  corr_t mon_e;
  int checks = 0;
  int errors = 0;

  cv32e40p_if_id_tmr_scrub_ctrl #(.ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lane_valid_i(lane_valid), .lane_rdata_i(lane_rdata), .lane_pc_i(lane_pc), .lane_flags_i(lane_flags),
    .voted_valid_o(voted_valid), .voted_rdata_o(voted_rdata), .voted_pc_o(voted_pc), .voted_flags_o(voted_flags),
    .wr_en_o(wr_en), .wr_valid_o(wr_valid), .wr_rdata_o(wr_rdata), .wr_pc_o(wr_pc), .wr_flags_o(wr_flags),
    .stall_o(stall), .corr_o(corr), .lane_en_o(lane_en), .err_cnt_o(err_cnt), .fatal_o(fatal),
    .clr_cnt_i(clr_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every correction pulse must match the oldest expected rewrite.
  always @(negedge clk) begin
    if (rst_n && corr) begin
      checks++;
      if (corr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_corr got wr_en=%b want no correction", wr_en);
      end else begin
        mon_e = corr_q.pop_front();
        if ({wr_en, wr_rdata, wr_pc, wr_valid, wr_flags} !== mon_e) begin
          errors++;
          $display("FAIL corr_bundle got %h want %h", {wr_en, wr_rdata, wr_pc, wr_valid, wr_flags}, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_clean();
    lane_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      lane_rdata[i] = NOP;
      lane_pc[i]    = PC;
      lane_flags[i] = 3'b000;
    end
  endtask

  task automatic push_corr(input logic [2:0] en);
    corr_q.push_back('{en: en, rdata: NOP, pc: PC, valid: 1'b1, flags: 3'b000});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_clean();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive_clean();
    tick();
    tick();
    checks++;
    if ({lane_en, err_cnt, fatal} !== {3'b111, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got en=%b cnt=%h fatal=%b want 111/000/0", lane_en, err_cnt, fatal);
    end
    checks++;
    if ({stall, corr, wr_en, wr_valid, wr_rdata, wr_pc, wr_flags} !== 73'd0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b corr=%b wr_en=%b wr_rdata=%h want zeros", stall, corr, wr_en, wr_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    drive_clean();
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if ({voted_valid, voted_rdata, voted_pc, voted_flags, stall, corr, err_cnt} !== {1'b1, NOP, PC, 3'b000, 2'b00, 9'd0}) begin
        errors++;
        $display("FAIL clean_cycle%0d got rdata=%h pc=%h stall=%b corr=%b cnt=%h", c, voted_rdata, voted_pc, stall, corr, err_cnt);
      end
    end
  endtask

  task automatic test_single_fault();
    lane_rdata[1] = NOP ^ 32'h20;
    #1;
    checks++;
    if (voted_rdata !== NOP) begin
      errors++;
      $display("FAIL single_vote got %h want %h", voted_rdata, NOP);
    end
    push_corr(3'b010);
    tick();
    drive_clean();
    checks++;
    if ({stall, corr, wr_en, err_cnt[1]} !== {2'b11, 3'b010, 3'd1}) begin
      errors++;
      $display("FAIL single_correct got stall=%b corr=%b wr_en=%b cnt1=%0d want 1/1/010/1", stall, corr, wr_en, err_cnt[1]);
    end
    tick();
    checks++;
    if ({stall, corr, wr_en} !== 5'd0) begin
      errors++;
      $display("FAIL single_release got stall=%b corr=%b wr_en=%b want 0/0/000", stall, corr, wr_en);
    end
  endtask

  task automatic test_double_fault();
    lane_pc[0]    = PC ^ 32'h1;
    lane_rdata[2] = NOP ^ 32'h8;
    push_corr(3'b101);
    tick();
    drive_clean();
    checks++;
    if ({wr_en, err_cnt[0], err_cnt[1], err_cnt[2]} !== {3'b101, 3'd1, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL double_fault got wr_en=%b cnt=%h want 101 cnt 1/1/1", wr_en, err_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    lane_rdata[1] = NOP ^ 32'h400;
    push_corr(3'b010);
    tick();
    tick();
    checks++;
    if ({corr, stall, err_cnt[1]} !== {2'b00, 3'd2}) begin
      errors++;
      $display("FAIL b2b_ignored got corr=%b stall=%b cnt1=%0d want 0/0/2", corr, stall, err_cnt[1]);
    end
    push_corr(3'b010);
    tick();
    drive_clean();
    checks++;
    if ({corr, err_cnt[1]} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL b2b_second got corr=%b cnt1=%0d want 1/3", corr, err_cnt[1]);
    end
    tick();
  endtask

  task automatic test_clr_collision();
    do_reset();
    lane_rdata[0] = NOP ^ 32'h1000;
    clr_cnt = 1'b1;
    push_corr(3'b001);
    tick();
    clr_cnt = 1'b0;
    drive_clean();
    checks++;
    if ({corr, err_cnt[0]} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL clr_collide got corr=%b cnt0=%0d want 1/0", corr, err_cnt[0]);
    end
    tick();
  endtask

  task automatic test_retire();
    do_reset();
    for (int k = 0; k < ERR_THRESH; k++) begin
      lane_rdata[2] = NOP ^ 32'h100;
      push_corr(3'b100);
      tick();
      drive_clean();
      tick();
      checks++;
      if (lane_en !== ((k == ERR_THRESH - 1) ? 3'b011 : 3'b111)) begin
        errors++;
        $display("FAIL retire_fault%0d got lane_en=%b cnt2=%0d", k, lane_en, err_cnt[2]);
      end
    end
    lane_rdata[2] = 32'hdead_beef;
    #1;
    checks++;
    if (voted_rdata !== NOP) begin
      errors++;
      $display("FAIL retired_vote got %h want %h", voted_rdata, NOP);
    end
    tick();
    tick();
    checks++;
    if ({stall, corr, fatal, err_cnt[2]} !== {3'b000, 3'd4}) begin
      errors++;
      $display("FAIL retired_ignored got stall=%b corr=%b fatal=%b cnt2=%0d", stall, corr, fatal, err_cnt[2]);
    end
    drive_clean();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if ({err_cnt[2], lane_en} !== {3'd0, 3'b011}) begin
      errors++;
      $display("FAIL clr_keeps_retired got cnt2=%0d lane_en=%b want 0/011", err_cnt[2], lane_en);
    end
  endtask

  task automatic test_fail_two_lane();
    lane_valid[1] = 1'b0;
    #1;
    checks++;
    if (voted_valid !== 1'b1) begin
      errors++;
      $display("FAIL two_lane_vote got %b want 1", voted_valid);
    end
    tick();
    drive_clean();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({fatal, stall, wr_en} !== 5'b11000) begin
        errors++;
        $display("FAIL fatal_hold%0d got fatal=%b stall=%b wr_en=%b", c, fatal, stall, wr_en);
      end
      tick();
    end
    do_reset();
    checks++;
    if ({fatal, stall, lane_en, err_cnt} !== {2'b00, 3'b111, 9'd0}) begin
      errors++;
      $display("FAIL post_fatal_reset got fatal=%b stall=%b lane_en=%b cnt=%h", fatal, stall, lane_en, err_cnt);
    end
  endtask

  task automatic test_reset_in_correct();
    lane_rdata[1] = NOP ^ 32'h2;
    tick();
    checks++;
    if (wr_en !== 3'b010) begin
      errors++;
      $display("FAIL pre_abort got wr_en=%b want 010", wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, stall, corr} !== 5'd0) begin
      errors++;
      $display("FAIL abort got wr_en=%b stall=%b corr=%b want 0", wr_en, stall, corr);
    end
    drive_clean();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (wr_en !== 3'b000) begin
        errors++;
        $display("FAIL post_abort%0d got wr_en=%b want 000", c, wr_en);
      end
    end
  endtask

  task automatic test_double_retire();
    do_reset();
    for (int k = 0; k < ERR_THRESH; k++) begin
      lane_rdata[0] = NOP ^ 32'h1;
      lane_rdata[1] = NOP ^ 32'h2;
      push_corr(3'b011);
      tick();
      drive_clean();
      tick();
    end
    checks++;
    if ({fatal, stall, lane_en} !== {2'b11, 3'b111}) begin
      errors++;
      $display("FAIL double_retire got fatal=%b stall=%b lane_en=%b want 1/1/111", fatal, stall, lane_en);
    end
    do_reset();
  endtask

  initial begin
    drive_clean();
    test_reset();
    test_clean();
    test_single_fault();
    test_double_fault();
    test_back_to_back();
    test_clr_collision();
    test_retire();
    test_fail_two_lane();
    test_reset_in_correct();
    test_double_retire();
    tick();
    checks++;
    if (corr_q.size() != 0) begin
      errors++;
      $display("FAIL missing_corr got %0d pending want 0", corr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
